// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch/retire sequencer.
// Holds the state encoding, the PC increment and the branch-offset helper.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } seq_state_t;

    localparam logic [31:0] PC_STEP              = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Word offset of a 16-bit branch immediate, sign-extended to 32 bits.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// Combinational next-PC selection: sequential, conditional branch, or jump.
// Jump takes priority over a branch when both are flagged.
module next_pc_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr_low,
    input  logic        zero,
    input  logic        branch,
    input  logic        branch_test,
    input  logic        jump,
    output logic [31:0] pc_next
);

    logic [31:0] pc4;
    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic        take;

    assign pc4     = pc + PC_STEP;
    assign btarget = pc4 + branch_offset(instr_low[15:0]);
    assign jtarget = {pc4[31:28], instr_low, 2'b00};

    // branch_test selects the sense: 0 takes on zero (beq), 1 on non-zero (bne).
    assign take    = branch & (branch_test ^ zero);

    assign pc_next = jump ? jtarget : (take ? btarget : pc4);

endmodule

// File: rtl/pc_sequencer.sv
// Per-instruction fetch/decode/execute/retire sequencer owning the architectural PC.
// All handshake outputs are Moore decodes of the state register.
//
//   state  | meaning
//   IDLE   | one quiet cycle after reset
//   FETCH  | imem_req high, imem_addr = pc, waiting for imem_ack
//   DECODE | instr_valid pulse for the freshly latched instruction
//   EXEC   | waiting for exec_done, then commit pc_next and count retirement
//   HALT   | everything frozen until reset
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] RETIRED_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        Zero,
    input  logic        Branch,
    input  logic        BranchTest,
    input  logic        Jump,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retired_q;
    logic [31:0] pc_next;
    logic        fetch_fire;
    logic        retire_fire;

    next_pc_calc u_next_pc (
        .pc          (pc_q),
        .instr_low   (instr_q[25:0]),
        .zero        (Zero),
        .branch      (Branch),
        .branch_test (BranchTest),
        .jump        (Jump),
        .pc_next     (pc_next)
    );

    assign fetch_fire  = (state == FETCH) && imem_ack;
    assign retire_fire = (state == EXEC) && exec_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc_q      <= RESET_VECTOR;
            instr_q   <= '0;
            retired_q <= RETIRED_RESET;
        end else begin
            state <= state_next;
            if (fetch_fire) begin
                instr_q <= imem_rdata;
            end
            if (retire_fire) begin
                pc_q      <= pc_next;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (imem_ack) state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    if (exec_done) state_next = halt ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == DECODE);
    assign halted      = (state == HALT);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign retired     = retired_q;

endmodule
